// File: rtl/mem_resp_pkg.sv
// ---------------------------------------------------------------------------
// mem_resp_pkg
// Shared definitions for the two-port memory arbiter/responder:
//   - state_t : controller states (IDLE, ACCESS, DONE)
//   - port_t  : requester identity (PORT_I = instruction fetch, PORT_D = data)
//   - LATENCY_DEF / DEPTH_LOG2_DEF : default parameter values for the top
//   - rrPick  : round-robin choice between the two requesters
// ---------------------------------------------------------------------------
package mem_resp_pkg;

    localparam int LATENCY_DEF    = 4;
    localparam int DEPTH_LOG2_DEF = 15;
    localparam int WORD_W         = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    // Picks the winner for this cycle. On a tie the port that did not win
    // last time is chosen; with no request at all the result is unused.
    function automatic port_t rrPick(input logic  iReq,
                                     input logic  dReq,
                                     input port_t lastGrant);
        port_t pick;
        pick = PORT_D;
        if (iReq && dReq) begin
            pick = (lastGrant == PORT_I) ? PORT_D : PORT_I;
        end else if (iReq) begin
            pick = PORT_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// ---------------------------------------------------------------------------
// mem_word_array
// Single-port synchronous 16-bit word store. One access per enabled cycle:
// a write stores din at idx, a read registers the word at idx onto dout.
// dout keeps its value on writes and on idle cycles. No reset: contents
// survive a controller reset.
// Ports:
//   clk  in  clock, rising edge
//   en   in  access enable
//   wr   in  1 = write, 0 = read (when en)
//   idx  in  word index
//   din  in  write data
//   dout out registered read data
// ---------------------------------------------------------------------------
module mem_word_array #(
    parameter int IDX_W = 15
) (
    input  logic             clk,
    input  logic             en,
    input  logic             wr,
    input  logic [IDX_W-1:0] idx,
    input  logic [15:0]      din,
    output logic [15:0]      dout
);

    logic [15:0] r_mem [0:(1<<IDX_W)-1];
    logic [15:0] r_dout;

    // The storage and its read register share one clocked block so that a
    // single enabled cycle performs either the write or the read, never both.
    always_ff @(posedge clk) begin
        if (en) begin
            if (wr) begin
                r_mem[idx] <= din;
            end else begin
                r_dout <= r_mem[idx];
            end
        end
    end

    assign dout = r_dout;

endmodule

// File: rtl/mem_arb_responder.sv
// ---------------------------------------------------------------------------
// mem_arb_responder
// Arbitrates an instruction-fetch read port and a data read/write port onto
// one word array. A request is captured in IDLE, the controller waits in
// ACCESS for LATENCY-1 cycles (touching the array on the last one), then
// pulses the granted port's rdy in DONE. Ties are resolved round-robin with
// the data port winning the first tie after reset.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   i_req, i_addr   fetch request and byte address
//   i_rdy, i_data   fetch completion pulse and fetched word (held)
//   d_req, d_wr     data request, 1 = write
//   d_addr, d_wdata data byte address and write word
//   d_rdy, d_rdata  data completion pulse and read word (held)
//   busy            high whenever the controller is not IDLE
// ---------------------------------------------------------------------------
module mem_arb_responder
    import mem_resp_pkg::*;
#(
    parameter int LATENCY    = LATENCY_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_rdy,
    output logic [15:0] i_data,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_rdy,
    output logic [15:0] d_rdata,
    output logic        busy
);

    state_t                r_state;
    port_t                 r_port;
    port_t                 r_lastGrant;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                  r_wr;
    logic [15:0]           r_wdata;
    logic [3:0]            r_cnt;
    logic                  r_iRdy;
    logic                  r_dRdy;
    logic                  r_busy;
    logic [15:0]           r_iData;
    logic [15:0]           r_dRdata;

    logic                  w_anyReq;
    port_t                 w_grant;
    logic                  w_lastAccess;
    logic [15:0]           w_dout;
    logic                  w_showI;
    logic                  w_showD;
    logic                  w_unusedAddrBits;

    // Arbitration only matters in IDLE; the FSM ignores it elsewhere, which
    // is what makes a request held through DONE count as a fresh one later.
    always_comb begin
        w_anyReq     = i_req | d_req;
        w_grant      = rrPick(i_req, d_req, r_lastGrant);
        w_lastAccess = (r_state == ACCESS) && (r_cnt == 4'd0);
    end

    // Address bit 0 and bits above the word index are don't-care so that
    // addresses wrap; collect them here so they are visibly consumed.
    assign w_unusedAddrBits = ^{i_addr, d_addr};

    // Main controller. Everything the transaction needs is captured in the
    // accept cycle so requesters may change their inputs afterwards. The
    // counter starts at LATENCY-2 and the array is touched when it reaches 0,
    // giving LATENCY-1 ACCESS cycles. An asynchronous reset drops straight
    // to IDLE, so an in-flight write never reaches the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_port      <= PORT_I;
            r_lastGrant <= PORT_I;
            r_idx       <= '0;
            r_wr        <= 1'b0;
            r_wdata     <= 16'h0000;
            r_cnt       <= 4'd0;
            r_iRdy      <= 1'b0;
            r_dRdy      <= 1'b0;
            r_busy      <= 1'b0;
            r_iData     <= 16'h0000;
            r_dRdata    <= 16'h0000;
        end else begin
            r_iRdy <= 1'b0;
            r_dRdy <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_port      <= w_grant;
                        r_lastGrant <= w_grant;
                        r_idx       <= (w_grant == PORT_I) ? i_addr[DEPTH_LOG2:1]
                                                           : d_addr[DEPTH_LOG2:1];
                        r_wr        <= (w_grant == PORT_D) && d_wr;
                        r_wdata     <= d_wdata;
                        r_cnt       <= 4'(LATENCY - 2);
                        r_busy      <= 1'b1;
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_iRdy  <= (r_port == PORT_I);
                        r_dRdy  <= (r_port == PORT_D);
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (!r_wr) begin
                        if (r_port == PORT_I) begin
                            r_iData <= w_dout;
                        end else begin
                            r_dRdata <= w_dout;
                        end
                    end
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    mem_word_array #(
        .IDX_W (DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .en   (w_lastAccess),
        .wr   (r_wr),
        .idx  (r_idx),
        .din  (r_wdata),
        .dout (w_dout)
    );

    // The array's read register already holds the word during DONE, so the
    // data outputs present it directly in that cycle and the per-port hold
    // registers take it over at the end of DONE. Writes leave them alone.
    always_comb begin
        w_showI = (r_state == DONE) && (r_port == PORT_I);
        w_showD = (r_state == DONE) && (r_port == PORT_D) && !r_wr;
    end

    assign i_data  = w_showI ? w_dout : r_iData;
    assign d_rdata = w_showD ? w_dout : r_dRdata;
    assign i_rdy   = r_iRdy;
    assign d_rdy   = r_dRdy;
    assign busy    = r_busy;

endmodule

// File: tb/tb_mem_arb_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_arb_responder
// Directed bench for mem_arb_responder. Single transactions come from a
// table of hand-computed records; multi-cycle cases (held requests, ties,
// reset during a write) are written out as short sequences.
// Cycle k is the interval after the k-th rising edge of the sequence;
// inputs change 1 ns after a rising edge, outputs are read on falling edges.
// ---------------------------------------------------------------------------
module tb_mem_arb_responder;

    localparam int LAT = 4;
    localparam int DL2 = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = 16'h0000;
    logic        i_rdy;
    logic [15:0] i_data;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = 16'h0000;
    logic [15:0] d_wdata = 16'h0000;
    logic        d_rdy;
    logic [15:0] d_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic        iReq;
        logic [15:0] iAddr;
        logic        dReq;
        logic        dWr;
        logic [15:0] dAddr;
        logic [15:0] dWdata;
        logic        expIRdy;
        logic        expDRdy;
        logic [15:0] expIData;
        logic [15:0] expDRdata;
    } vec_t;

    vec_t vecs [0:10];

    always #5 clk = ~clk;

    mem_arb_responder #(
        .LATENCY    (LAT),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdy   (i_rdy),
        .i_data  (i_data),
        .d_req   (d_req),
        .d_wr    (d_wr),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdy   (d_rdy),
        .d_rdata (d_rdata),
        .busy    (busy)
    );

    // Drives every requester input at once.
    task automatic applyStimulus(input logic ir, input logic [15:0] ia,
                                 input logic dr, input logic dw,
                                 input logic [15:0] da, input logic [15:0] dwd);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_wr    = dw;
        d_addr  = da;
        d_wdata = dwd;
    endtask

    // One comparison: counts it and reports it when it does not match.
    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
    endtask

    // One transaction from IDLE. Inputs are scrambled right after the accept
    // edge; the captured values must carry the transaction regardless.
    task automatic runTxn(input vec_t v);
        logic [15:0] iMask;
        logic [15:0] dMask;
        logic [15:0] bMask;
        logic [15:0] expRdy;
        logic [15:0] expBusy;
        iMask   = 16'h0000;
        dMask   = 16'h0000;
        bMask   = 16'h0000;
        expRdy  = 16'h0001 << LAT;
        expBusy = ((16'h0001 << (LAT + 1)) - 16'h0001) & 16'hFFFE;
        applyStimulus(v.iReq, v.iAddr, v.dReq, v.dWr, v.dAddr, v.dWdata);
        for (int c = 0; c <= LAT + 1; c++) begin
            @(negedge clk);
            iMask[c] = i_rdy;
            dMask[c] = d_rdy;
            bMask[c] = busy;
            if (c == LAT) begin
                checkOutput({v.name, ".iData"}, i_data, v.expIData);
                checkOutput({v.name, ".dRdata"}, d_rdata, v.expDRdata);
            end
            nextCycle();
            if (c == 0) begin
                applyStimulus(1'b0, ~v.iAddr, 1'b0, ~v.dWr, v.dAddr ^ 16'h0006, ~v.dWdata);
            end
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput({v.name, ".iRdyCycles"}, iMask, v.expIRdy ? expRdy : 16'h0000);
        checkOutput({v.name, ".dRdyCycles"}, dMask, v.expDRdy ? expRdy : 16'h0000);
        checkOutput({v.name, ".busyCycles"}, bMask, expBusy);
    endtask

    // Requests held high through cycle 10, observed over cycles 0..15.
    task automatic runHeld(input string name, input logic ir, input logic [15:0] ia,
                           input logic dr, input logic [15:0] da,
                           input logic [15:0] expIMask, input logic [15:0] expDMask,
                           input int iAt, input logic [15:0] expIData,
                           input int dAt, input logic [15:0] expDData);
        logic [15:0] iMask;
        logic [15:0] dMask;
        logic [15:0] bMask;
        iMask = 16'h0000;
        dMask = 16'h0000;
        bMask = 16'h0000;
        applyStimulus(ir, ia, dr, 1'b0, da, 16'h0000);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            iMask[c] = i_rdy;
            dMask[c] = d_rdy;
            bMask[c] = busy;
            if (c == iAt) checkOutput({name, ".iData"}, i_data, expIData);
            if (c == dAt) checkOutput({name, ".dRdata"}, d_rdata, expDData);
            nextCycle();
            if (c == 10) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        end
        checkOutput({name, ".iRdyCycles"}, iMask, expIMask);
        checkOutput({name, ".dRdyCycles"}, dMask, expDMask);
        checkOutput({name, ".busyCycles"}, bMask, 16'h7BDE);
    endtask

    initial begin
        logic [15:0] iMask;
        logic [15:0] dMask;
        logic [15:0] bMask;

        //          name      iReq  iAddr     dReq  dWr   dAddr     dWdata    iRdy  dRdy  iData     dRdata
        vecs[0]  = '{"wr10",   1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b1, 16'h0000, 16'h0000};
        vecs[1]  = '{"rd11",   1'b0, 16'h0000, 1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'hBEEF};
        vecs[2]  = '{"wr0",    1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'hA5A5, 1'b0, 1'b1, 16'h0000, 16'hBEEF};
        vecs[3]  = '{"rdWrap", 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'hA5A5};
        vecs[4]  = '{"wr22",   1'b0, 16'h0000, 1'b1, 1'b1, 16'h0022, 16'h1357, 1'b0, 1'b1, 16'h0000, 16'hA5A5};
        vecs[5]  = '{"iRdHi",  1'b1, 16'hFC23, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h1357, 16'hA5A5};
        vecs[6]  = '{"wr20",   1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h5555, 1'b0, 1'b1, 16'h1357, 16'hA5A5};
        vecs[7]  = '{"wr40",   1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'hCAFE, 1'b0, 1'b1, 16'h1357, 16'hA5A5};
        vecs[8]  = '{"rd40",   1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b1, 16'h1357, 16'hCAFE};
        vecs[9]  = '{"iRd10",  1'b1, 16'h0010, 1'b0, 1'b1, 16'h0010, 16'hDEAD, 1'b1, 1'b0, 16'hBEEF, 16'hCAFE};
        vecs[10] = '{"rd10",   1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 16'hBEEF};

        // Reset held with both requests high: nothing may start.
        rst = 1'b1;
        applyStimulus(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0010, 16'hFFFF);
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("rst.iRdy", {15'b0, i_rdy}, 16'h0000);
        checkOutput("rst.dRdy", {15'b0, d_rdy}, 16'h0000);
        checkOutput("rst.busy", {15'b0, busy}, 16'h0000);
        checkOutput("rst.iData", i_data, 16'h0000);
        checkOutput("rst.dRdata", d_rdata, 16'h0000);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        rst = 1'b0;
        nextCycle();

        for (int k = 0; k < 11; k++) begin
            runTxn(vecs[k]);
        end

        // Reset in cycle 2 of a write: no rdy, and the old word survives.
        iMask = 16'h0000;
        dMask = 16'h0000;
        bMask = 16'h0000;
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234);
        for (int c = 0; c < 8; c++) begin
            if (c == 2) rst = 1'b1;
            if (c == 3) rst = 1'b0;
            @(negedge clk);
            iMask[c] = i_rdy;
            dMask[c] = d_rdy;
            bMask[c] = busy;
            nextCycle();
            if (c == 0) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        end
        checkOutput("abort.iRdyCycles", iMask, 16'h0000);
        checkOutput("abort.dRdyCycles", dMask, 16'h0000);
        checkOutput("abort.busyCycles", bMask, 16'h0002);
        checkOutput("abort.dRdataCleared", d_rdata, 16'h0000);
        runTxn('{"abortRd", 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000,
                 1'b0, 1'b1, 16'h0000, 16'h5555});

        // First tie after reset goes to data, then instruction, then data.
        doReset();
        runHeld("tie", 1'b1, 16'h0000, 1'b1, 16'h0011,
                16'h0200, 16'h4010, 9, 16'hA5A5, 4, 16'hBEEF);

        // Instruction request held high: one fetch every LATENCY+1 cycles.
        runHeld("iHold", 1'b1, 16'h0020, 1'b0, 16'h0000,
                16'h4210, 16'h0000, 4, 16'h5555, 4, 16'hBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
